// File: rtl/pll_supervisor.sv
// pll_supervisor
// Free-running supervisor for the board PLL, clocked by the 50 MHz reference.
// It pulses the PLL reset, waits for a qualified lock, and holds the system
// reset until lock has been stable for STABLE_CYCLES. It re-locks on its own
// after a loss of lock, a lock timeout, or an explicit re-init request.
//
// Ports:
//   refclk       in   reference clock, free-running
//   rst          in   asynchronous active-high reset
//   locked       in   PLL lock indicator, asynchronous to refclk
//   reinit_req   in   single-cycle request to force a PLL reset sequence
//   pll_rst      out  PLL reset, active-high (high only in RESET_PLL)
//   sys_rst      out  system reset, active-high (low only in RUN)
//   ready        out  high only in RUN
//   state        out  current state encoding (see table)
//   relock_count out  saturating count of lock losses seen in RUN
//   retry_count  out  saturating count of WAIT_LOCK timeouts
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE    | lock seen, qualifying it for STABLE_CYCLES consecutive cycles
// RUN       | lock qualified, system reset released

module pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       reinit_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] relock_count,
    output logic [3:0] retry_count
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       relock_d;
    logic [3:0]       retry_d;
    logic             locked_meta, locked_s;

    // Two-flop synchronizer; every decision below uses locked_s only.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= locked;
            locked_s    <= locked_meta;
        end
    end

    // Priority inside each state: reinit_req, then lock change, then count expiry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        relock_d = relock_count;
        retry_d  = retry_count;
        case (state_q)
            RESET_PLL: begin
                // reinit_req is ignored here so the current pulse is never stretched
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (reinit_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_count != 4'hF) retry_d = retry_count + 4'd1;
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (reinit_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (!locked_s) begin
                    // a glitch restarts qualification without touching the PLL
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (reinit_req) begin
                    state_d = RESET_PLL;
                end else if (!locked_s) begin
                    if (relock_count != 8'hFF) relock_d = relock_count + 8'd1;
                    state_d = RESET_PLL;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register and always agree with it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            relock_count <= 8'd0;
            retry_count  <= 4'd0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            relock_count <= relock_d;
            retry_count  <= retry_d;
            pll_rst      <= (state_d == RESET_PLL);
            sys_rst      <= (state_d != RUN);
            ready        <= (state_d == RUN);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_supervisor.sv
module tb_pll_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 8;

    localparam logic [16:0] RESET_VEC = 17'b1_1_0_00_00000000_0000;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       reinit_req;
    logic       pll_rst, sys_rst, ready;
    logic [1:0] state;
    logic [7:0] relock_count;
    logic [3:0] retry_count;

    int checks = 0;
    int errors = 0;

    pll_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .reinit_req  (reinit_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .state       (state),
        .relock_count(relock_count),
        .retry_count (retry_count)
    );

    always #5 refclk = ~refclk;

    wire [16:0] dut_vec = {pll_rst, sys_rst, ready, state, relock_count, retry_count};

    // Reference model: which phase we are in, how many cycles have been spent
    // in it, the two most recent lock samples, and the two event tallies.
    int m_phase;   // 0 pll reset, 1 waiting, 2 qualifying, 3 running
    int m_age;
    int m_relock;
    int m_retry;
    logic m_seen1, m_seen2;

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_relock = 0; m_retry = 0;
        m_seen1 = 1'b0; m_seen2 = 1'b0;
    endtask

    task automatic model_enter(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_edge();
        logic lock_view;
        lock_view = m_seen2;          // lock as seen two edges ago
        m_seen2   = m_seen1;
        m_seen1   = locked;
        m_age     = m_age + 1;
        if (m_phase == 0) begin
            if (m_age == RST_CYCLES) model_enter(1);
        end else if (reinit_req) begin
            model_enter(0);
        end else if (m_phase == 1) begin
            if (lock_view) model_enter(2);
            else if (m_age == LOCK_TIMEOUT) begin
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                model_enter(0);
            end
        end else if (m_phase == 2) begin
            if (!lock_view) model_enter(1);
            else if (m_age == STABLE_CYCLES) model_enter(3);
        end else begin
            if (!lock_view) begin
                m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                model_enter(0);
            end
        end
    endtask

    function automatic logic [16:0] model_vec();
        return {(m_phase == 0), (m_phase != 3), (m_phase == 3), 2'(m_phase),
                8'(m_relock), 4'(m_retry)};
    endfunction

    task automatic step();
        @(posedge refclk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        reinit_req = 1'b0;
        model_reset();
        @(posedge refclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; locked = 1'b0; reinit_req = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec, RESET_VEC);
        end
        locked = 1'b1;
        @(posedge refclk); #1;
        @(posedge refclk); #1;
        rst = 1'b0;
        locked = 1'b0;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_nominal();
        int n, k;
        apply_reset();
        locked = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin step(); n++; end
        checks++;
        if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL nominal_pulse: got %0d cycles expected %0d", n, RST_CYCLES);
        end
        repeat (10 - RST_CYCLES) step();
        locked = 1'b1;
        // one edge to capture, two synchronizer stages, then qualification
        k = 0;
        while (sys_rst === 1'b1 && k < 100) begin step(); k++; end
        checks++;
        if (k != 1 + 2 + STABLE_CYCLES) begin
            errors++;
            $display("FAIL nominal_release: got %0d edges expected %0d", k, 1 + 2 + STABLE_CYCLES);
        end
        checks++;
        if (ready !== 1'b1 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL nominal_run: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_timeout();
        int n, m, p;
        apply_reset();
        locked = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin step(); n++; end
        m = 0;
        while (pll_rst === 1'b0 && m < 100) begin step(); m++; end
        checks++;
        if (m != LOCK_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_wait: got %0d cycles expected %0d", m, LOCK_TIMEOUT);
        end
        p = 0;
        while (pll_rst === 1'b1 && p < 100) begin step(); p++; end
        checks++;
        if (p != RST_CYCLES || retry_count !== 4'd1) begin
            errors++;
            $display("FAIL timeout_repulse: got pulse %0d retry %0d expected pulse %0d retry 1",
                     p, retry_count, RST_CYCLES);
        end
        for (int i = 0; i < 16; i++) begin
            m = 0;
            while (pll_rst === 1'b0 && m < 100) begin step(); m++; end
            p = 0;
            while (pll_rst === 1'b1 && p < 100) begin step(); p++; end
        end
        checks++;
        if (retry_count !== 4'd15 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL timeout_saturate: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_glitch();
        int w, s;
        logic saw_pll;
        apply_reset();
        locked = 1'b1;
        w = 0;
        while (state !== 2'd2 && w < 100) begin step(); w++; end
        repeat (3) step();
        locked = 1'b0;
        step();
        locked = 1'b1;
        saw_pll = 1'b0;
        w = 0;
        while (state !== 2'd1 && w < 20) begin step(); w++; if (pll_rst) saw_pll = 1'b1; end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL glitch_to_wait: got state %0d expected 1", state);
        end
        w = 0;
        while (state === 2'd1 && w < 20) begin step(); w++; if (pll_rst) saw_pll = 1'b1; end
        s = 0;
        while (state === 2'd2 && s < 100) begin step(); s++; if (pll_rst) saw_pll = 1'b1; end
        checks++;
        if (s != STABLE_CYCLES || state !== 2'd3) begin
            errors++;
            $display("FAIL glitch_requalify: got %0d cycles state %0d expected %0d state 3",
                     s, state, STABLE_CYCLES);
        end
        checks++;
        if (saw_pll !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_pll_rst: got pll_rst pulse expected none");
        end
    endtask

    task automatic test_run_loss();
        int w, k;
        apply_reset();
        locked = 1'b1;
        w = 0;
        while (ready !== 1'b1 && w < 100) begin step(); w++; end
        for (int r = 0; r < 256; r++) begin
            locked = 1'b0;
            k = 0;
            while (sys_rst === 1'b0 && k < 10) begin step(); k++; end
            if (r == 0) begin
                checks++;
                if (k != 3 || pll_rst !== 1'b1 || relock_count !== 8'd1) begin
                    errors++;
                    $display("FAIL run_loss_first: got edges %0d pll_rst %b relock %0d expected 3 1 1",
                             k, pll_rst, relock_count);
                end
            end
            locked = 1'b1;
            w = 0;
            while (ready !== 1'b1 && w < 100) begin step(); w++; end
        end
        checks++;
        if (relock_count !== 8'd255 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL run_loss_saturate: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_reinit_coincident();
        int w, n;
        apply_reset();
        locked = 1'b1;
        w = 0;
        while (ready !== 1'b1 && w < 100) begin step(); w++; end
        locked = 1'b0;
        step();
        step();
        reinit_req = 1'b1;   // arrives on the edge that first sees the loss
        step();
        reinit_req = 1'b0;
        checks++;
        if (state !== 2'd0 || pll_rst !== 1'b1 || relock_count !== 8'd0) begin
            errors++;
            $display("FAIL reinit_coincident: got state %0d pll_rst %b relock %0d expected 0 1 0",
                     state, pll_rst, relock_count);
        end
        // now in the first cycle of the pulse; a reinit mid-pulse must not stretch it
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin
            reinit_req = (n == 1);
            step();
            n++;
        end
        reinit_req = 1'b0;
        checks++;
        if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL reinit_in_reset: got pulse %0d expected %0d", n, RST_CYCLES);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reinit_model: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_async_rst();
        int w;
        apply_reset();
        locked = 1'b1;
        w = 0;
        while (state !== 2'd2 && w < 100) begin step(); w++; end
        step();
        step();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL async_rst: got %h expected %h", dut_vec, RESET_VEC);
        end
        @(posedge refclk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        locked = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) locked = ~locked;
            reinit_req = ($urandom_range(0, 63) == 0);
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        reinit_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_glitch();
        test_run_loss();
        test_reinit_coincident();
        test_async_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
